// File: rtl/x_23k640_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : x_23k640_ctrl
// Brief    : Single-byte read/write responder for one 23K640 SPI SRAM (mode 0).
//            Optional power-up WRSR byte-mode frame: X_23K640_MODE_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module x_23k640_ctrl #(
    parameter int p_clk_div = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_rd_n_wr,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_accept,
    output logic        o_ready,
    output logic [7:0]  o_rdata,
    output logic        o_sck,
    output logic        o_cs_n,
    output logic        o_si,
    input  logic        i_so
);

    localparam int c_cnt_w = (p_clk_div > 1) ? $clog2(p_clk_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(p_clk_div - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_HOLD  = 3'd2,
        S_GAP   = 3'd3,
        S_INIT  = 3'd4
    } state_t;

`ifdef X_23K640_MODE_INIT_EN
    localparam state_t c_rst_state = S_INIT;
    localparam logic   c_init_rst  = 1'b1;
`else
    localparam state_t c_rst_state = S_IDLE;
    localparam logic   c_init_rst  = 1'b0;
`endif

    state_t               r_state, w_state_next;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
    logic                 r_hi, w_hi_next;
    logic [4:0]           r_bit, w_bit_next;
    logic [31:0]          r_frame, w_frame_next;
    logic [7:0]           r_so, w_so_next;
    logic                 r_rd, w_rd_next;
    logic                 r_init, w_init_next;
    logic                 r_ready, w_ready_next;
    logic [7:0]           r_rdata, w_rdata_next;
    logic                 w_accept;
    logic [4:0]           w_last_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_rst_state;
            r_cnt   <= '0;
            r_hi    <= 1'b0;
            r_bit   <= '0;
            r_frame <= '0;
            r_so    <= '0;
            r_rd    <= 1'b0;
            r_init  <= c_init_rst;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_bit   <= w_bit_next;
            r_frame <= w_frame_next;
            r_so    <= w_so_next;
            r_rd    <= w_rd_next;
            r_init  <= w_init_next;
            r_ready <= w_ready_next;
            r_rdata <= w_rdata_next;
        end
    end

    // The WRSR init frame is only 16 bits long; every user frame is 32.
    assign w_last_bit = r_init ? 5'd15 : 5'd31;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_bit_next   = r_bit;
        w_frame_next = r_frame;
        w_so_next    = r_so;
        w_rd_next    = r_rd;
        w_init_next  = r_init;
        w_ready_next = 1'b0;
        w_rdata_next = r_rdata;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid && i_rst_n) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                    w_rd_next    = i_rd_n_wr;
                    w_frame_next = {(i_rd_n_wr ? 8'h03 : 8'h02), i_addr,
                                    (i_rd_n_wr ? 8'h00 : i_wdata)};
                    w_cnt_next   = '0;
                    w_hi_next    = 1'b0;
                    w_bit_next   = '0;
                end
            end
            S_INIT: begin
                w_state_next = S_SHIFT;
                w_frame_next = {8'h01, 8'h00, 16'h0000};
                w_cnt_next   = '0;
                w_hi_next    = 1'b0;
                w_bit_next   = '0;
            end
            S_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next = '0;
                    if (!r_hi) begin
                        // This edge raises SCK: capture SO here.
                        w_hi_next = 1'b1;
                        w_so_next = {r_so[6:0], i_so};
                    end else begin
                        w_hi_next    = 1'b0;
                        w_frame_next = {r_frame[30:0], 1'b0};
                        if (r_bit == w_last_bit) begin
                            w_state_next = S_HOLD;
                        end else begin
                            w_bit_next = r_bit + 5'd1;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_GAP;
                    if (!r_init) begin
                        w_ready_next = 1'b1;
                        if (r_rd) begin
                            w_rdata_next = r_so;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                    w_init_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_accept = w_accept;
    assign o_ready  = r_ready;
    assign o_rdata  = r_rdata;
    assign o_sck    = (r_state == S_SHIFT) && r_hi;
    assign o_cs_n   = !((r_state == S_SHIFT) || (r_state == S_HOLD));
    assign o_si     = (r_state == S_SHIFT) && r_frame[31];

endmodule
`default_nettype wire
